mpy_accum: RTL and testbench
============================

MPY_ACCUM -- requirements
Module: mpy_accum

Interface
REQ-001 SHALL have parameter NA, default 18, multiplier operand A width.
REQ-002 SHALL have parameter NB, default 18, multiplier operand B width.
REQ-003 SHALL have parameter NACC, default 48, accumulator and result width, with NACC >= NA+NB.
REQ-004 SHALL have parameter LGN, default 8, product-count width.
REQ-005 SHALL have ports, one per line:
  i_clk  in  1  clock; all logic on rising edge
  i_reset  in  1  synchronous, active-high reset
  i_done  in  1  multiplier done level; product valid on its rising edge
  i_p  in  NA+NB  signed product from the multiplier
  i_aux  in  1  last-of-group flag, qualified with the product
  o_hold  out  1  backpressure; upstream SHALL NOT start a new multiply while high
  o_valid  out  1  result available
  i_ready  in  1  consumer accepts the result
  o_sum  out  NACC  signed group sum
  o_count  out  LGN  number of products in the group
  o_ovfl  out  1  group sum saturated
  o_err  out  1  sticky; a completed group was dropped

Function
REQ-006 SHALL define a product event as i_done high while the registered i_done (done_q) was low; a level held high SHALL produce exactly one event.
REQ-007 SHALL sign-extend i_p to NACC bits before every add.
REQ-008 SHALL use two states: S_IDLE (no group open) and S_ACC (group open).
REQ-009 SHALL, on an event in S_IDLE, load acc = sext(i_p) and count = 1, then go to S_ACC (or deliver immediately per REQ-011 if i_aux=1).
REQ-010 SHALL, on an event in S_ACC, set acc = sat(acc + sext(i_p)) and count = count+1; count SHALL saturate at 2^LGN-1.
REQ-011 SHALL, on an event with i_aux=1, form the final sum including that product, load it into the output register, and return to S_IDLE with acc and count cleared.
REQ-012 SHALL saturate the sum to +2^(NACC-1)-1 or -2^(NACC-1) on signed overflow and set the group overflow flag; later adds in that group SHALL keep the saturated value.
REQ-013 SHALL have a latency of one cycle: o_valid rises on the cycle after the last-product event.
REQ-014 SHALL hold o_valid, o_sum, o_count and o_ovfl stable until the cycle after o_valid && i_ready.
REQ-015 SHALL assert o_hold = o_valid && !i_ready, registered-free (combinational).
REQ-016 SHALL, when a group completes while o_valid && !i_ready, discard the new result, keep the held output, and set o_err.
REQ-017 SHALL, when a group completes in the same cycle as o_valid && i_ready, load the new result with no drop and keep o_valid high.
REQ-018 SHALL take no action on events when no event is present; i_p and i_aux are don't-care.

Reset
REQ-019 SHALL, on i_reset, clear o_valid, o_sum, o_count, o_ovfl, o_err, acc, count and done_q, and enter S_IDLE.
REQ-020 SHALL give reset priority over a simultaneous event; that product SHALL be lost.
REQ-021 SHALL discard any open group when reset occurs mid-group.

Structure
REQ-022 SHALL place the state encoding (S_IDLE, S_ACC) and the saturation limit constants in a shared package, mpy_pkg.
REQ-023 SHALL implement the saturating signed add as sub-module mpy_sat_add, parameterised by NACC.

Verification
REQ-024 SHALL cover: products 3, -5, 7 with i_aux on 7 -> o_sum=5, o_count=3, o_ovfl=0, o_valid one cycle after the third event.
REQ-025 SHALL cover: i_done held high for 10 cycles with i_p=4 and i_aux=1 -> exactly one result, o_sum=4, o_count=1.
REQ-026 SHALL cover: NACC=36, with two products each +2^34 and the second carrying i_aux -> o_sum = 2^35-1 and o_ovfl=1.
REQ-027 SHALL cover: result held with i_ready=0 and a second group completes -> first result unchanged, o_err=1, o_hold=1.
REQ-028 SHALL cover: i_ready=1 in the same cycle a new group completes -> new o_sum is presented, o_valid stays high, o_err=0.
REQ-029 SHALL cover: i_reset asserted after two products of an open group -> all outputs are 0, and the next group of a single product 9 yields o_sum=9.

Source files
------------

// File: rtl/mpy_pkg.sv
// Shared definitions for the multiply-accumulate block.
//   state_e  : group FSM encoding (S_IDLE = no group open, S_ACC = group open)
//   sat_max  : most positive signed value for a given width
//   sat_min  : most negative signed value for a given width
// The limit helpers return MaxNacc-bit values; callers size them to their own width.
package mpy_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_e;

  localparam int unsigned MaxNacc = 128;

  function automatic logic [MaxNacc-1:0] sat_max(input int unsigned w);
    return (MaxNacc'(1) << (w - 1)) - MaxNacc'(1);
  endfunction

  function automatic logic [MaxNacc-1:0] sat_min(input int unsigned w);
    return MaxNacc'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/mpy_sat_add.sv
// Saturating signed adder.
//   a_i, b_i : signed addends, NACC bits
//   sum_o    : a_i + b_i, clamped to the signed NACC-bit range
//   ovfl_o   : high when the clamp was applied
module mpy_sat_add
  import mpy_pkg::*;
#(
  parameter int unsigned NACC = 48
) (
  input  logic [NACC-1:0] a_i,
  input  logic [NACC-1:0] b_i,
  output logic [NACC-1:0] sum_o,
  output logic            ovfl_o
);

  localparam logic [NACC-1:0] SatMax = NACC'(sat_max(NACC));
  localparam logic [NACC-1:0] SatMin = NACC'(sat_min(NACC));

  logic [NACC-1:0] raw;

  assign raw = a_i + b_i;

  // Overflow only when both operands share a sign and the result sign differs.
  assign ovfl_o = (a_i[NACC-1] == b_i[NACC-1]) && (raw[NACC-1] != a_i[NACC-1]);
  assign sum_o  = ovfl_o ? (a_i[NACC-1] ? SatMin : SatMax) : raw;

endmodule

// File: rtl/mpy_accum.sv
// Group accumulator for a multiplier's product stream.
// Products arrive on rising edges of i_done; i_aux marks the last product of a group.
// The saturated group sum, product count and overflow flag are presented one cycle
// after the last product with a valid/ready handshake.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_done, i_p    : done level and NA+NB-bit signed product
//   i_aux          : last-of-group flag, qualified with the product event
//   o_hold         : upstream must not start a new multiply while high
//   o_valid/i_ready: result handshake; o_sum/o_count/o_ovfl held while pending
//   o_err          : sticky, a completed group was dropped on a stalled output
module mpy_accum
  import mpy_pkg::*;
#(
  parameter int unsigned NA   = 18,
  parameter int unsigned NB   = 18,
  parameter int unsigned NACC = 48,
  parameter int unsigned LGN  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_done,
  input  logic [NA+NB-1:0]   i_p,
  input  logic               i_aux,
  output logic               o_hold,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NACC-1:0]    o_sum,
  output logic [LGN-1:0]     o_count,
  output logic               o_ovfl,
  output logic               o_err
);

  state_e          state_q, state_d;
  logic            done_q;
  logic [NACC-1:0] acc_q, acc_d;
  logic [LGN-1:0]  count_q, count_d;
  logic            govf_q, govf_d;
  logic            valid_q, valid_d;
  logic [NACC-1:0] sum_q, sum_d;
  logic [LGN-1:0]  cnt_q, cnt_d;
  logic            ovfl_q, ovfl_d;
  logic            err_q, err_d;

  logic            evt;
  logic [NACC-1:0] p_ext;
  logic [NACC-1:0] add_a;
  logic [NACC-1:0] add_sum;
  logic            add_ovf;
  logic [NACC-1:0] grp_sum;
  logic [LGN-1:0]  grp_cnt;
  logic            grp_ovf;

  assign evt   = i_done && !done_q;
  assign p_ext = NACC'($signed(i_p));
  // In S_IDLE the adder sees zero, so the first product loads unchanged.
  assign add_a = (state_q == S_ACC) ? acc_q : '0;

  mpy_sat_add #(
    .NACC (NACC)
  ) u_sat_add (
    .a_i    (add_a),
    .b_i    (p_ext),
    .sum_o  (add_sum),
    .ovfl_o (add_ovf)
  );

  // Group state including the current product, used whether or not it closes the group.
  always_comb begin
    grp_sum = add_sum;
    grp_cnt = LGN'(1);
    grp_ovf = add_ovf;
    unique case (state_q)
      S_IDLE: begin
        grp_sum = add_sum;
        grp_cnt = LGN'(1);
        grp_ovf = add_ovf;
      end
      S_ACC: begin
        // Once saturated, the group sum is pinned for the rest of the group.
        grp_sum = govf_q ? acc_q : add_sum;
        grp_cnt = (&count_q) ? count_q : count_q + LGN'(1);
        grp_ovf = govf_q || add_ovf;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    govf_d  = govf_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovfl_d  = ovfl_q;
    err_d   = err_q;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    if (evt) begin
      if (i_aux) begin
        state_d = S_IDLE;
        acc_d   = '0;
        count_d = '0;
        govf_d  = 1'b0;
        if (valid_q && !i_ready) begin
          err_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          sum_d   = grp_sum;
          cnt_d   = grp_cnt;
          ovfl_d  = grp_ovf;
        end
      end else begin
        state_d = S_ACC;
        acc_d   = grp_sum;
        count_d = grp_cnt;
        govf_d  = grp_ovf;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      acc_q   <= '0;
      count_q <= '0;
      govf_q  <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovfl_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= i_done;
      acc_q   <= acc_d;
      count_q <= count_d;
      govf_q  <= govf_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovfl_q  <= ovfl_d;
      err_q   <= err_d;
    end
  end

  assign o_hold  = valid_q && !i_ready;
  assign o_valid = valid_q;
  assign o_sum   = sum_q;
  assign o_count = cnt_q;
  assign o_ovfl  = ovfl_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_mpy_accum.sv
module tb_mpy_accum;

  logic        clk = 1'b0;
  logic        rst;

  // Default-width instance.
  logic        a_done, a_aux, a_ready;
  logic [35:0] a_p;
  logic        a_hold, a_valid, a_ovfl, a_err;
  logic [47:0] a_sum;
  logic [7:0]  a_count;

  // NACC = NA+NB = 36 instance for saturation cases.
  logic        b_done, b_aux, b_ready;
  logic [35:0] b_p;
  logic        b_hold, b_valid, b_ovfl, b_err;
  logic [35:0] b_sum;
  logic [7:0]  b_count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mpy_accum u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_done  (a_done),
    .i_p     (a_p),
    .i_aux   (a_aux),
    .o_hold  (a_hold),
    .o_valid (a_valid),
    .i_ready (a_ready),
    .o_sum   (a_sum),
    .o_count (a_count),
    .o_ovfl  (a_ovfl),
    .o_err   (a_err)
  );

  mpy_accum #(
    .NA   (18),
    .NB   (18),
    .NACC (36),
    .LGN  (8)
  ) u_dut36 (
    .i_clk   (clk),
    .i_reset (rst),
    .i_done  (b_done),
    .i_p     (b_p),
    .i_aux   (b_aux),
    .o_hold  (b_hold),
    .o_valid (b_valid),
    .i_ready (b_ready),
    .o_sum   (b_sum),
    .o_count (b_count),
    .o_ovfl  (b_ovfl),
    .o_err   (b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One product on the default instance: rising edge, then drop i_done for a cycle.
  task automatic pulse_a(input logic [35:0] p, input logic aux);
    a_done = 1'b1;
    a_p    = p;
    a_aux  = aux;
    tick();
    a_done = 1'b0;
    a_aux  = 1'b0;
    tick();
  endtask

  // One product on the 36-bit instance; leaves the cycle right after the event for checks.
  task automatic pulse_b(input logic [35:0] p, input logic aux);
    b_done = 1'b1;
    b_p    = p;
    b_aux  = aux;
    tick();
    b_done = 1'b0;
    b_aux  = 1'b0;
  endtask

  int          nvalid;
  logic [47:0] seen_sum;
  logic [7:0]  seen_cnt;

  initial begin
    rst     = 1'b1;
    a_done  = 1'b0;
    a_p     = '0;
    a_aux   = 1'b0;
    a_ready = 1'b0;
    b_done  = 1'b0;
    b_p     = '0;
    b_aux   = 1'b0;
    b_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    check("reset_valid", a_valid, 0);
    check("reset_sum",   a_sum,   0);
    check("reset_count", a_count, 0);
    check("reset_ovfl",  a_ovfl,  0);
    check("reset_err",   a_err,   0);
    check("reset_hold",  a_hold,  0);

    // 3 + (-5) + 7 = 5 over three products.
    pulse_a(36'd3, 1'b0);
    pulse_a(36'hF_FFFF_FFFB, 1'b0);
    a_done = 1'b1;
    a_p    = 36'd7;
    a_aux  = 1'b1;
    check("grp3_valid_before", a_valid, 0);
    tick();
    a_done = 1'b0;
    a_aux  = 1'b0;
    check("grp3_valid", a_valid, 1);
    check("grp3_sum",   a_sum,   5);
    check("grp3_count", a_count, 3);
    check("grp3_ovfl",  a_ovfl,  0);
    check("grp3_hold",  a_hold,  1);
    tick();
    check("grp3_held_sum", a_sum, 5);
    a_ready = 1'b1;
    tick();
    check("grp3_accepted", a_valid, 0);
    check("grp3_hold_free", a_hold, 0);

    // Level held for 10 cycles: exactly one event.
    nvalid   = 0;
    seen_sum = '0;
    seen_cnt = '0;
    a_done   = 1'b1;
    a_p      = 36'd4;
    a_aux    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (a_valid) begin
        nvalid++;
        seen_sum = a_sum;
        seen_cnt = a_count;
      end
    end
    a_done  = 1'b0;
    a_aux   = 1'b0;
    tick();
    a_ready = 1'b0;
    check("level_results", 64'(nvalid), 1);
    check("level_sum",     seen_sum,    4);
    check("level_count",   seen_cnt,    1);

    // Second group completes while the first is stalled: dropped, err sticky.
    pulse_a(36'd10, 1'b1);
    check("stall_first_sum", a_sum, 10);
    pulse_a(36'd20, 1'b1);
    check("stall_keep_sum",  a_sum,   10);
    check("stall_valid",     a_valid, 1);
    check("stall_err",       a_err,   1);
    check("stall_hold",      a_hold,  1);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check("stall_drained",   a_valid, 0);
    check("stall_err_stick", a_err,   1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared", a_err, 0);

    // Accept and new completion in the same cycle: new result, no drop.
    pulse_a(36'd1, 1'b1);
    check("same_first_sum", a_sum, 1);
    a_done  = 1'b1;
    a_p     = 36'd2;
    a_aux   = 1'b1;
    a_ready = 1'b1;
    tick();
    a_done = 1'b0;
    a_aux  = 1'b0;
    check("same_valid", a_valid, 1);
    check("same_sum",   a_sum,   2);
    check("same_err",   a_err,   0);
    tick();
    a_ready = 1'b0;
    check("same_drained", a_valid, 0);

    // Reset wins over a simultaneous event.
    rst    = 1'b1;
    a_done = 1'b1;
    a_p    = 36'd5;
    a_aux  = 1'b1;
    tick();
    rst    = 1'b0;
    a_done = 1'b0;
    a_aux  = 1'b0;
    tick();
    check("rst_evt_valid", a_valid, 0);
    check("rst_evt_sum",   a_sum,   0);

    // Reset mid-group discards it; next single-product group stands alone.
    pulse_a(36'd6, 1'b0);
    pulse_a(36'd7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", a_valid, 0);
    check("mid_rst_sum",   a_sum,   0);
    check("mid_rst_count", a_count, 0);
    check("mid_rst_ovfl",  a_ovfl,  0);
    check("mid_rst_err",   a_err,   0);
    check("mid_rst_hold",  a_hold,  0);
    pulse_a(36'd9, 1'b1);
    check("after_rst_valid", a_valid, 1);
    check("after_rst_sum",   a_sum,   9);
    check("after_rst_count", a_count, 1);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;

    // Count saturates at 255 while the sum keeps counting.
    for (int i = 0; i < 299; i++) begin
      pulse_a(36'd1, 1'b0);
    end
    pulse_a(36'd1, 1'b1);
    check("cnt_sat_count", a_count, 255);
    check("cnt_sat_sum",   a_sum,   300);
    check("cnt_sat_ovfl",  a_ovfl,  0);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;

    // 2^34 + 2^34 overflows 36 bits: clamps to 2^35-1.
    pulse_b(36'h4_0000_0000, 1'b0);
    tick();
    pulse_b(36'h4_0000_0000, 1'b1);
    check("pos_sat_valid", b_valid, 1);
    check("pos_sat_sum",   b_sum,   64'h7_FFFF_FFFF);
    check("pos_sat_ovfl",  b_ovfl,  1);
    check("pos_sat_count", b_count, 2);
    tick();

    // Saturated value is kept through a later opposite-sign add.
    pulse_b(36'h4_0000_0000, 1'b0);
    tick();
    pulse_b(36'h4_0000_0000, 1'b0);
    tick();
    pulse_b(36'hF_FFFF_FFFB, 1'b1);
    check("sticky_sat_sum",   b_sum,   64'h7_FFFF_FFFF);
    check("sticky_sat_ovfl",  b_ovfl,  1);
    check("sticky_sat_count", b_count, 3);
    tick();

    // -2^34 * 2 lands exactly on the minimum without overflow.
    pulse_b(36'hC_0000_0000, 1'b0);
    tick();
    pulse_b(36'hC_0000_0000, 1'b1);
    check("min_exact_sum",  b_sum,  64'h8_0000_0000);
    check("min_exact_ovfl", b_ovfl, 0);
    tick();

    // A third -2^34 overflows negative.
    pulse_b(36'hC_0000_0000, 1'b0);
    tick();
    pulse_b(36'hC_0000_0000, 1'b0);
    tick();
    pulse_b(36'hC_0000_0000, 1'b1);
    check("neg_sat_sum",  b_sum,  64'h8_0000_0000);
    check("neg_sat_ovfl", b_ovfl, 1);
    check("b_err_clear",  b_err,  0);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
